// File: rtl/cpu_boot_mem.sv
// rtl/cpu_boot_mem.sv - Program RAM with stream boot loader that holds the CPU in reset until loaded.
// Header word gives the program length; words beyond DEPTH are accepted and dropped.
module cpu_boot_mem #(
  parameter int DEPTH    = 8192,
  parameter int RST_HOLD = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [15:0] ld_data,
  output logic        cpu_rst,
  input  logic        wrEn,
  input  logic [12:0] addr_toRAM,
  input  logic [15:0] data_toRAM,
  output logic [15:0] data_fromRAM,
  output logic        load_done,
  output logic        load_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_HDR  = 2'd0,
    S_LOAD = 2'd1,
    S_HOLD = 2'd2,
    S_RUN  = 2'd3
  } state_t;

  state_t       r_state;
  state_t       w_next;
  logic [16:0]  r_cnt;
  logic [15:0]  r_n;
  logic [15:0]  r_hold;
  logic         r_err;
  logic [15:0]  r_rdata;
  logic [15:0]  r_mem [0:DEPTH-1];

  logic         w_ld_ready;
  logic         w_hs;
  logic         w_last_word;
  logic         w_hold_done;
  logic         w_cpu_in_range;
  logic         w_ld_we;
  logic         w_cpu_we;
  logic [AW-1:0] w_waddr;
  logic [15:0]  w_wdata;

  // ready is a pure state decode, forced low while rst is asserted
  assign w_ld_ready     = ~rst & ((r_state == S_HDR) | (r_state == S_LOAD));
  assign w_hs           = ld_valid & w_ld_ready;
  assign w_last_word    = (r_cnt + 17'd1) == {1'b0, r_n};
  assign w_hold_done    = r_hold == 16'(RST_HOLD - 1);
  assign w_cpu_in_range = {19'd0, addr_toRAM} < DEPTH;

  assign ld_ready     = w_ld_ready;
  assign cpu_rst      = (r_state != S_RUN);
  assign load_done    = (r_state == S_RUN);
  assign load_err     = r_err;
  assign data_fromRAM = r_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_HDR;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_HDR: begin
        if (w_hs) begin
          w_next = (ld_data == 16'd0) ? S_HOLD : S_LOAD;
        end
      end
      S_LOAD: begin
        if (w_hs && w_last_word) begin
          w_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (w_hold_done) begin
          w_next = S_RUN;
        end
      end
      default: w_next = S_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= 17'd0;
      r_n    <= 16'd0;
      r_hold <= 16'd0;
      r_err  <= 1'b0;
    end else begin
      if (r_state == S_HDR && w_hs) begin
        r_n   <= ld_data;
        r_cnt <= 17'd0;
        if ({1'b0, ld_data} > 17'(DEPTH)) begin
          r_err <= 1'b1;
        end
      end else if (r_state == S_LOAD && w_hs) begin
        r_cnt <= r_cnt + 17'd1;
      end
      if (r_state == S_HOLD) begin
        r_hold <= r_hold + 16'd1;
      end else begin
        r_hold <= 16'd0;
      end
    end
  end

  // single write port shared by the loader and the CPU; their states never overlap
  assign w_ld_we  = (r_state == S_LOAD) & w_hs & (r_cnt < 17'(DEPTH));
  assign w_cpu_we = (r_state == S_RUN) & wrEn & w_cpu_in_range;
  assign w_waddr  = w_ld_we ? r_cnt[AW-1:0] : addr_toRAM[AW-1:0];
  assign w_wdata  = w_ld_we ? ld_data : data_toRAM;

  always_ff @(posedge clk) begin
    if (w_ld_we || w_cpu_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= 16'd0;
    end else if (r_state == S_RUN) begin
      r_rdata <= w_cpu_in_range ? r_mem[addr_toRAM[AW-1:0]] : 16'd0;
    end
  end

endmodule

// File: doc/cpu_boot_mem.md
# cpu_boot_mem

Program memory and boot loader sitting directly downstream of the 16-bit CPU's RAM port. It holds the 16-bit-wide RAM with one-cycle synchronous read that the CPU fetches from and writes to. After reset it first fills that RAM from a valid/ready word stream while keeping the CPU in reset. It then releases the CPU and serves its accesses.

## Interface
Parameters:
- DEPTH, 8192: number of 16-bit words implemented; legal range 1..8192.
- RST_HOLD, 2: cycles `cpu_rst` stays high after the last load write; minimum 1.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- ld_valid  input  1  load stream word valid.
- ld_ready  output  1  block accepts `ld_data` this cycle.
- ld_data  input  16  load stream word; first is header, rest are program words.
- cpu_rst  output  1  reset to the CPU; high during reset, load and hold.
- wrEn  input  1  CPU write enable.
- addr_toRAM  input  13  CPU word address.
- data_toRAM  input  16  CPU write data.
- data_fromRAM  output  16  registered read data to the CPU.
- load_done  output  1  high once the CPU is released.
- load_err  output  1  sticky; header exceeded DEPTH.

## Operation
- FSM states: HDR, LOAD, HOLD, RUN.
- Reset (`rst` high, asynchronous) forces the following, and holds them while `rst` is high:
  - state HDR, word counter 0, hold counter 0;
  - `ld_ready`=0, `cpu_rst`=1, `data_fromRAM`=0, `load_done`=0, `load_err`=0.
  - RAM contents are not cleared.
- HDR: `ld_ready`=1. A handshake (`ld_valid` & `ld_ready` at an edge) latches N=`ld_data` and clears the word counter.
  - N=0: next state HOLD.
  - Otherwise: next state LOAD. If N>DEPTH, set `load_err`=1.
- LOAD: `ld_ready`=1. Each handshake writes `ld_data` to mem[count] when count<DEPTH; words at count≥DEPTH are accepted and discarded. The count then increments.
  - The handshake with count=N-1 moves to HOLD.
  - `ld_valid` low stalls indefinitely with no state change.
- HOLD: `ld_ready`=0, `cpu_rst`=1. The hold counter counts RST_HOLD cycles, then the state moves to RUN.
- RUN: `cpu_rst`=0, `load_done`=1, `ld_ready`=0. Stream input is ignored for good; only `rst` returns the block to HDR.
- CPU port in HDR/LOAD/HOLD: `wrEn`, `addr_toRAM` and `data_toRAM` are ignored; no writes, and `data_fromRAM` holds its value.
- CPU port in RUN:
  - Each edge registers `data_fromRAM` = mem[`addr_toRAM`] if `addr_toRAM`<DEPTH, else 0.
  - `wrEn`=1 writes `data_toRAM` to mem[`addr_toRAM`] if `addr_toRAM`<DEPTH; writes to higher addresses are dropped silently.
  - Same-edge read and write of one address is read-first: `data_fromRAM` shows the old word and the new word is visible from the next read.
- Width rules:
  - N is the full 16-bit unsigned value; the word counter is 17 bits so N=65535 cannot wrap.
  - Addresses are 13-bit unsigned.

## Timing
- Load write latency: the word is in RAM at the handshake edge and readable by the CPU once in RUN.
- Last load handshake at edge T:
  - state HOLD after T;
  - `cpu_rst` falls and `load_done` rises after edge T+RST_HOLD.
  - The CPU therefore sees `cpu_rst` high at ≥RST_HOLD edges after loading.
- N=0: header handshake at edge T, RUN after edge T+RST_HOLD.
- Read latency is exactly one cycle. An address presented in cycle k appears on `data_fromRAM` in cycle k+1 and holds until the next edge. This matches the CPU's address-then-consume fetch.
- `ld_ready` is a decode of registered state only; it has no combinational path from `ld_valid`.
- `load_err` is set at the header edge and cleared only by `rst`.
- Reset mid-LOAD: contents written so far persist, state returns to HDR, and `cpu_rst` stays high throughout.

## Test plan
- **Basic load:** reset, stream header 3 then 0xC004, 0x0005, 0xE006 with `ld_valid` always high.
  - `ld_ready` high for 4 cycles; `cpu_rst` falls 2 edges after the last handshake.
  - CPU address 1 returns 0x0005 the next cycle; `load_err`=0.
- **Stalled stream:** insert 5 idle cycles between words 1 and 2.
  - No state advance during the gap, no spurious writes, and final RAM matches the stream.
- **Oversize header:** DEPTH=4, header 6, then six words 1..6.
  - `load_err`=1 and all 6 words accepted.
  - mem[0..3]=1..4, and reading address 5 in RUN returns 0.
- **Zero header:** header 0.
  - RUN two edges later, `ld_ready`=0 afterwards, RAM unchanged.
- **Run-time access:** CPU writes 0xBEEF to address 7 while reading address 7 in the same cycle.
  - `data_fromRAM` shows the old value; the next read of address 7 returns 0xBEEF.
  - A write to address 8191 with DEPTH=4096 is dropped and reads back 0.
- **Reset mid-load:** assert `rst` asynchronously (between edges) after 2 of 3 words.
  - All outputs go to reset values immediately.
  - A reload with a fresh header completes normally.
